// File: rtl/example_pkg.sv
// Shared types and sizing helpers for the beat packer and its FIFO.
//   DEF_*        default geometry of the packer
//   LANE_W(n)    width needed to count 0..n filled lanes
//   PTR_W(d)     FIFO pointer width: index bits plus one wrap bit
//   pack_word_t  packed-word payload {lanes, data} at the default geometry
package example_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_PACK_RATIO = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    // Lane-count width: must represent PACK_RATIO itself (a full word).
    function automatic int unsigned LANE_W(input int unsigned ratio);
        return $clog2(ratio + 1);
    endfunction

    // Pointer width: log2(depth) index bits plus the wrap bit.
    function automatic int unsigned PTR_W(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEF_LANES_W = LANE_W(DEF_PACK_RATIO);
    localparam int unsigned DEF_WORD_W  = DEF_DATA_WIDTH * DEF_PACK_RATIO;

    // Lane 0 (first sample) sits in the LSBs of data.
    typedef struct packed {
        logic [DEF_LANES_W-1:0] lanes;
        logic [DEF_WORD_W-1:0]  data;
    } pack_word_t;

endpackage

// File: rtl/example_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk_i, rst_n_i    clock, async active-low reset (empties FIFO, zeroes storage)
//   push_i, data_i    write request; accepted when not full, or when full with a pop
//   full_c            FIFO holds DEPTH entries
//   pop_i             read request; honoured only when not empty
//   empty_c           FIFO holds no entries
//   head_c            oldest entry, visible without a pop
module example_sync_fifo
    import example_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_c,
    input  logic             pop_i,
    output logic             empty_c,
    output logic [WIDTH-1:0] head_c
);

    localparam int unsigned PW = PTR_W(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means full; identical pointers mean empty.
    always_comb begin
        empty_c = (wr_q == rd_q);
        full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty_c;
        // A pop frees the slot the push lands in, so push+pop while full both succeed.
        do_push = push_i && (!full_c || do_pop);
        head_c  = mem[rd_q[AW-1:0]];
    end

    // Pointer registers; wrap-around is natural modulo 2*DEPTH.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/example_beat_packer.sv
// Packs PACK_RATIO consecutive samples into one wide word, buffers words in a
// FWFT FIFO and offers them on a ready/valid port. Upstream cannot stall, so a
// word arriving at a full FIFO is dropped, flagged (sticky) and counted.
//   clk_i, rst_n_i            clock, async active-low reset
//   data_i, valid_i           sample stream, no backpressure
//   flush_i                   push a partially filled word now
//   clr_ovf_i                 clear overflow_o and drop_cnt_o
//   pack_data_o/lanes_o       FIFO head word and its valid lane count
//   pack_valid_o/ready_i      bus-side handshake
//   overflow_o, drop_cnt_o    sticky drop flag and saturating drop counter
module example_beat_packer
    import example_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PACK_RATIO = DEF_PACK_RATIO,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    input  logic                             valid_i,
    input  logic                             flush_i,
    input  logic                             clr_ovf_i,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] pack_data_o,
    output logic [$clog2(PACK_RATIO+1)-1:0]  pack_lanes_o,
    output logic                             pack_valid_o,
    input  logic                             pack_ready_i,
    output logic                             overflow_o,
    output logic [CNT_WIDTH-1:0]             drop_cnt_o
);

    localparam int unsigned LW     = LANE_W(PACK_RATIO);
    localparam int unsigned WORD_W = DATA_WIDTH * PACK_RATIO;
    localparam int unsigned FW     = LW + WORD_W;

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_next;
    logic [LW-1:0]     lane_q;
    logic [LW-1:0]     lane_next;
    logic              word_done;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     push_word;
    logic [FW-1:0]     head_word;

    // Accumulate this cycle's sample, then decide whether a word leaves.
    always_comb begin
        acc_next  = acc_q;
        lane_next = lane_q;
        if (valid_i) begin
            for (int l = 0; l < PACK_RATIO; l++) begin
                if (lane_q == LW'(l)) acc_next[l*DATA_WIDTH +: DATA_WIDTH] = data_i;
            end
            lane_next = lane_q + LW'(1);
        end
        word_done = valid_i && (lane_q == LW'(PACK_RATIO - 1));
        // Flush sees the count including a same-cycle sample; empty flush does nothing.
        push      = word_done || (flush_i && (lane_next != '0));
        push_word = {lane_next, acc_next};
    end

    // Accumulator and lane counter; cleared whenever a word leaves, dropped or not.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q  <= '0;
            lane_q <= '0;
        end else if (push) begin
            acc_q  <= '0;
            lane_q <= '0;
        end else begin
            acc_q  <= acc_next;
            lane_q <= lane_next;
        end
    end

    // A push is lost only when the FIFO is full and nothing leaves this cycle.
    always_comb begin
        pop  = pack_ready_i && !fifo_empty;
        drop = push && fifo_full && !pop;
    end

    // Sticky flag and saturating counter; a drop outranks a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (clr_ovf_i)                drop_cnt_o <= CNT_WIDTH'(1);
            else if (drop_cnt_o != '1)    drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
        end else if (clr_ovf_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end
    end

    example_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (push_word),
        .full_c  (fifo_full),
        .pop_i   (pack_ready_i),
        .empty_c (fifo_empty),
        .head_c  (head_word)
    );

    // Head is driven straight from FIFO storage so it holds steady under stall.
    assign pack_valid_o                = !fifo_empty;
    assign {pack_lanes_o, pack_data_o} = head_word;

endmodule
